// File: rtl/lifo_bank_if.sv
// lifo_bank_if: request/response bundle for the lifo_bank stack bank.
// master = sequencer issuing ops, slave = the bank.
interface lifo_bank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int NUM_STACKS = 4
);
   localparam int SEL_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                  op_valid;
   logic                  op_ready;
   logic [SEL_W-1:0]      op_sel;
   logic                  op_push;
   logic                  op_pop;
   logic [DATA_WIDTH-1:0] op_data;

   logic                  rsp_valid;
   logic [SEL_W-1:0]      rsp_sel;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic [CNT_W-1:0]      rsp_count;
   logic                  rsp_err;

   modport master (
      output op_valid, op_sel, op_push, op_pop, op_data,
      input  op_ready, rsp_valid, rsp_sel, rsp_data, rsp_count, rsp_err
   );

   modport slave (
      input  op_valid, op_sel, op_push, op_pop, op_data,
      output op_ready, rsp_valid, rsp_sel, rsp_data, rsp_count, rsp_err
   );
endinterface

// File: rtl/lifo_bank.sv
// lifo_bank: NUM_STACKS independent LIFOs sharing one register array.
// One op per cycle (push / pop / replace-top / peek), registered response
// one cycle after accept. Optional sticky overflow/underflow flags are
// compiled in with `define LIFO_BANK_ERR_STATUS_EN.
module lifo_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int NUM_STACKS = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   lifo_bank_if.slave            bus,
   output logic [NUM_STACKS-1:0] empty,
   output logic [NUM_STACKS-1:0] full
`ifdef LIFO_BANK_ERR_STATUS_EN
   ,
   input  logic [NUM_STACKS-1:0] err_clr,
   output logic [NUM_STACKS-1:0] ovf_sticky,
   output logic [NUM_STACKS-1:0] udf_sticky
`endif
);
   localparam int SEL_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int MEM_N = NUM_STACKS * DEPTH;
   localparam int AW    = (MEM_N > 1) ? $clog2(MEM_N) : 1;
   localparam logic [SEL_W:0]   NS_LIM  = (SEL_W + 1)'(NUM_STACKS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [MEM_N];
   logic [CNT_W-1:0]      count_q [NUM_STACKS];

   logic                  accept;
   logic                  sel_ok;
   logic [SEL_W-1:0]      sel_i;
   logic [CNT_W-1:0]      cur_cnt;
   logic                  is_empty;
   logic                  is_full;
   logic [CNT_W-1:0]      top_slot;
   logic [AW-1:0]         base_addr;
   logic [AW-1:0]         top_addr;
   logic [AW-1:0]         push_addr;
   logic [DATA_WIDTH-1:0] top_data;

   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic [CNT_W-1:0]      nxt_cnt;
   logic [DATA_WIDTH-1:0] rsp_data_d;
   logic                  rsp_err_d;
   logic [CNT_W-1:0]      rsp_count_d;

   logic                  rsp_valid_q;
   logic [SEL_W-1:0]      rsp_sel_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic [CNT_W-1:0]      rsp_count_q;
   logic                  rsp_err_q;

   // Ready is simply "not in reset": the bank never stalls an op.
   assign bus.op_ready = ~reset;
   assign accept       = bus.op_valid & bus.op_ready;

   // Illegal selects are steered to stack 0 for the lookups but never commit.
   assign sel_ok    = {1'b0, bus.op_sel} < NS_LIM;
   assign sel_i     = sel_ok ? bus.op_sel : '0;
   assign cur_cnt   = count_q[sel_i];
   assign is_empty  = (cur_cnt == '0);
   assign is_full   = (cur_cnt == CNT_MAX);
   assign top_slot  = is_empty ? '0 : cur_cnt - CNT_W'(1);
   assign base_addr = AW'(32'(sel_i) * 32'(DEPTH));
   assign top_addr  = base_addr + AW'(top_slot);
   assign push_addr = base_addr + AW'(cur_cnt);
   assign top_data  = mem[top_addr];

   // Op decode: next count, memory write and response contents.
   always_comb begin
      wr_en      = 1'b0;
      wr_addr    = push_addr;
      nxt_cnt    = cur_cnt;
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
      if (!sel_ok) begin
         rsp_err_d = 1'b1;
      end else begin
         unique case ({bus.op_push, bus.op_pop})
            2'b10: begin
               if (!is_full) begin
                  wr_en      = 1'b1;
                  nxt_cnt    = cur_cnt + CNT_W'(1);
                  rsp_data_d = bus.op_data;
               end else begin
                  rsp_err_d  = 1'b1;
               end
            end
            2'b01: begin
               if (!is_empty) begin
                  nxt_cnt    = cur_cnt - CNT_W'(1);
                  rsp_data_d = top_data;
               end else begin
                  rsp_err_d  = 1'b1;
               end
            end
            2'b11: begin
               // Replace-top; on an empty stack the word just passes through.
               if (!is_empty) begin
                  wr_en      = 1'b1;
                  wr_addr    = top_addr;
                  rsp_data_d = top_data;
               end else begin
                  rsp_data_d = bus.op_data;
               end
            end
            default: begin
               if (!is_empty) rsp_data_d = top_data;
               else           rsp_err_d  = 1'b1;
            end
         endcase
      end
      rsp_count_d = sel_ok ? nxt_cnt : '0;
   end

   // Storage array; contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (accept && wr_en) mem[wr_addr] <= bus.op_data;
   end

   // Per-stack occupancy, updated on the same edge as the write.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_STACKS; i++) count_q[i] <= '0;
      end else if (accept && sel_ok) begin
         count_q[sel_i] <= nxt_cnt;
      end
   end

   // Response register: one pulse per accepted op, fields held otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_sel_q   <= '0;
         rsp_data_q  <= '0;
         rsp_count_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= accept;
         if (accept) begin
            rsp_sel_q   <= bus.op_sel;
            rsp_data_q  <= rsp_data_d;
            rsp_count_q <= rsp_count_d;
            rsp_err_q   <= rsp_err_d;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_sel   = rsp_sel_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_count = rsp_count_q;
   assign bus.rsp_err   = rsp_err_q;

   // Status flags straight from the registered counts.
   always_comb begin
      empty = '0;
      full  = '0;
      for (int i = 0; i < NUM_STACKS; i++) begin
         empty[i] = (count_q[i] == '0);
         full[i]  = (count_q[i] == CNT_MAX);
      end
   end

`ifdef LIFO_BANK_ERR_STATUS_EN
   logic ovf_evt;
   logic udf_evt;

   // Rejected push -> overflow; rejected pop or peek -> underflow.
   assign ovf_evt = accept & sel_ok & bus.op_push & ~bus.op_pop & is_full;
   assign udf_evt = accept & sel_ok & ~bus.op_push & is_empty;

   // Sticky error flags; a new event wins over a same-cycle clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         ovf_sticky <= '0;
         udf_sticky <= '0;
      end else begin
         for (int i = 0; i < NUM_STACKS; i++) begin
            if (ovf_evt && (sel_i == SEL_W'(i)))  ovf_sticky[i] <= 1'b1;
            else if (err_clr[i])                  ovf_sticky[i] <= 1'b0;
            if (udf_evt && (sel_i == SEL_W'(i)))  udf_sticky[i] <= 1'b1;
            else if (err_clr[i])                  udf_sticky[i] <= 1'b0;
         end
      end
   end
`endif
endmodule

// File: tb/tb_lifo_bank.sv
// tb_lifo_bank: directed stimulus with a per-stack array model and a
// per-cycle comparator, plus literal checks on the hand-worked sequences.
module tb_lifo_bank;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int NS    = 5;
   localparam int SEL_W = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   lifo_bank_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_STACKS(NS)) bus ();
   logic [NS-1:0] empty, full;
`ifdef LIFO_BANK_ERR_STATUS_EN
   logic [NS-1:0] err_clr, ovf_sticky, udf_sticky;
`endif

   lifo_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_STACKS(NS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .empty (empty),
      .full  (full)
`ifdef LIFO_BANK_ERR_STATUS_EN
      ,
      .err_clr    (err_clr),
      .ovf_sticky (ovf_sticky),
      .udf_sticky (udf_sticky)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_mem [NS][DEPTH];
   int            m_cnt [NS];
   bit            started = 1'b0;
   bit            exp_valid = 1'b0;
   int            exp_sel, exp_cnt;
   logic [DW-1:0] exp_data;
   bit            exp_err;
   int            s, c;

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NS; i++) m_cnt[i] = 0;
         exp_valid = 1'b0;
         started   = 1'b1;
      end else if (bus.op_valid) begin
         s = int'(bus.op_sel);
         exp_valid = 1'b1;
         exp_sel   = s;
         exp_err   = 1'b0;
         exp_data  = '0;
         exp_cnt   = 0;
         if (s >= NS) begin
            exp_err = 1'b1;
         end else begin
            c = m_cnt[s];
            if (bus.op_push && !bus.op_pop) begin
               if (c < DEPTH) begin
                  m_mem[s][c] = bus.op_data;
                  m_cnt[s]    = c + 1;
                  exp_data    = bus.op_data;
               end else exp_err = 1'b1;
            end else if (!bus.op_push && bus.op_pop) begin
               if (c > 0) begin
                  exp_data = m_mem[s][c-1];
                  m_cnt[s] = c - 1;
               end else exp_err = 1'b1;
            end else if (bus.op_push && bus.op_pop) begin
               if (c > 0) begin
                  exp_data      = m_mem[s][c-1];
                  m_mem[s][c-1] = bus.op_data;
               end else exp_data = bus.op_data;
            end else begin
               if (c > 0) exp_data = m_mem[s][c-1];
               else       exp_err  = 1'b1;
            end
            exp_cnt = m_cnt[s];
         end
      end else begin
         exp_valid = 1'b0;
      end
   end

   // ---------------- per-cycle comparator ----------------
   logic [NS-1:0] m_empty, m_full;
   always @(negedge clock) begin
      if (started) begin
         for (int i = 0; i < NS; i++) begin
            m_empty[i] = (m_cnt[i] == 0);
            m_full[i]  = (m_cnt[i] == DEPTH);
         end
         chk("op_ready", 64'(bus.op_ready), 64'(!reset));
         chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
         if (exp_valid) begin
            chk("rsp_sel",   64'(bus.rsp_sel),   64'(exp_sel));
            chk("rsp_data",  64'(bus.rsp_data),  64'(exp_data));
            chk("rsp_count", 64'(bus.rsp_count), 64'(exp_cnt));
            chk("rsp_err",   64'(bus.rsp_err),   64'(exp_err));
         end
         chk("empty", 64'(empty), 64'(m_empty));
         chk("full",  64'(full),  64'(m_full));
      end
   end

   // ---------------- drivers ----------------
   task automatic do_op(input int sel, input bit psh, input bit pp, input logic [DW-1:0] d);
      bus.op_valid = 1'b1;
      bus.op_sel   = SEL_W'(sel);
      bus.op_push  = psh;
      bus.op_pop   = pp;
      bus.op_data  = d;
      @(posedge clock); #1;
      bus.op_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.op_valid = 1'b0;
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic pulse_reset();
      bus.op_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      bus.op_valid = 1'b0;
      bus.op_sel   = '0;
      bus.op_push  = 1'b0;
      bus.op_pop   = 1'b0;
      bus.op_data  = '0;
`ifdef LIFO_BANK_ERR_STATUS_EN
      err_clr = '0;
`endif
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready",     64'(bus.op_ready),  64'(0));
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_rsp_data",  64'(bus.rsp_data),  64'(0));
      chk("rst_rsp_count", 64'(bus.rsp_count), 64'(0));
      chk("rst_empty",     64'(empty),         64'h1f);
      chk("rst_full",      64'(full),          64'h0);
      reset = 1'b0;
      #1;
      chk("ready_after_rst", 64'(bus.op_ready), 64'(1));

      // LIFO order on stack 1
      do_op(1, 1, 0, 32'hA);
      do_op(1, 1, 0, 32'hB);
      do_op(1, 1, 0, 32'hC);
      do_op(1, 0, 1, 0); chk("pop1_data", 64'(bus.rsp_data), 64'hC); chk("pop1_cnt", 64'(bus.rsp_count), 64'd2);
      do_op(1, 0, 1, 0); chk("pop2_data", 64'(bus.rsp_data), 64'hB); chk("pop2_cnt", 64'(bus.rsp_count), 64'd1);
      do_op(1, 0, 1, 0); chk("pop3_data", 64'(bus.rsp_data), 64'hA); chk("pop3_cnt", 64'(bus.rsp_count), 64'd0);
      chk("empty1", 64'(empty[1]), 64'd1);

      // Overflow on stack 0
      for (int k = 0; k < 4; k++) do_op(0, 1, 0, 32'h100 + 32'(k));
      chk("fill_err", 64'(bus.rsp_err), 64'd0);
      chk("full0_at4", 64'(full[0]), 64'd1);
      do_op(0, 1, 0, 32'h104);
      chk("ovf_err",  64'(bus.rsp_err),   64'd1);
      chk("ovf_cnt",  64'(bus.rsp_count), 64'd4);
      chk("ovf_data", 64'(bus.rsp_data),  64'd0);
      chk("ovf_full", 64'(full[0]),       64'd1);
      do_op(0, 0, 1, 0); chk("after_ovf_pop", 64'(bus.rsp_data), 64'h103);
      repeat (3) do_op(0, 0, 1, 0);
      chk("drain_last", 64'(bus.rsp_data), 64'h100);

      // Empty-stack behaviour on stack 2
      do_op(2, 0, 1, 0); chk("udf_pop_err", 64'(bus.rsp_err), 64'd1); chk("udf_pop_data", 64'(bus.rsp_data), 64'd0);
      do_op(2, 0, 0, 0); chk("udf_peek_err", 64'(bus.rsp_err), 64'd1); chk("udf_peek_data", 64'(bus.rsp_data), 64'd0);
      do_op(2, 1, 1, 32'h55);
      chk("pass_data", 64'(bus.rsp_data), 64'h55);
      chk("pass_err",  64'(bus.rsp_err),  64'd0);
      chk("pass_cnt",  64'(bus.rsp_count), 64'd0);

      // Replace-top and peek
      do_op(0, 1, 0, 32'h11);
      do_op(0, 1, 1, 32'h22); chk("repl_data", 64'(bus.rsp_data), 64'h11); chk("repl_cnt", 64'(bus.rsp_count), 64'd1);
      do_op(0, 0, 0, 0);      chk("peek_data", 64'(bus.rsp_data), 64'h22); chk("peek_cnt", 64'(bus.rsp_count), 64'd1);
      do_op(0, 0, 1, 0);      chk("repl_pop",  64'(bus.rsp_data), 64'h22);

      // Interleaved stacks 0 and 3
      do_op(0, 1, 0, 32'h1);
      do_op(3, 1, 0, 32'h2);
      do_op(0, 1, 0, 32'h3);
      do_op(3, 1, 0, 32'h4);
      do_op(0, 0, 1, 0); chk("il_s0_a", 64'(bus.rsp_data), 64'h3);
      do_op(0, 0, 1, 0); chk("il_s0_b", 64'(bus.rsp_data), 64'h1);
      do_op(3, 0, 1, 0); chk("il_s3_a", 64'(bus.rsp_data), 64'h4);
      do_op(3, 0, 1, 0); chk("il_s3_b", 64'(bus.rsp_data), 64'h2);

      // Illegal selects leave everything alone
      do_op(4, 1, 0, 32'h77);
      do_op(5, 1, 0, 32'hDEAD);
      chk("ill_err",  64'(bus.rsp_err),   64'd1);
      chk("ill_data", 64'(bus.rsp_data),  64'd0);
      chk("ill_cnt",  64'(bus.rsp_count), 64'd0);
      do_op(7, 0, 1, 0); chk("ill7_err", 64'(bus.rsp_err), 64'd1);
      do_op(4, 0, 0, 0); chk("ill_keep", 64'(bus.rsp_data), 64'h77); chk("ill_keep_cnt", 64'(bus.rsp_count), 64'd1);
      do_op(4, 0, 1, 0);

      // Reset right after an accepted pop
      do_op(2, 1, 0, 32'h9);
      do_op(2, 1, 0, 32'h9);
      do_op(0, 1, 0, 32'h5);
      do_op(2, 0, 1, 0); chk("pre_rst_pop", 64'(bus.rsp_data), 64'h9);
      pulse_reset();
      chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
      chk("mid_rst_empty", 64'(empty),         64'h1f);
      chk("mid_rst_data",  64'(bus.rsp_data),  64'd0);
      do_op(2, 0, 0, 0); chk("mid_rst_peek", 64'(bus.rsp_err), 64'd1);

      // Mixed directed sequence, checked by the model every cycle
      for (int i = 0; i < 48; i++) begin
         int code;
         code = (i * 3 + i / 5) % 4;
         if (i % 7 == 6) idle(1);
         do_op(i % 6, code >= 2, (code % 2) == 1, 32'(i) * 32'h01010101 + 32'd7);
      end

`ifdef LIFO_BANK_ERR_STATUS_EN
      pulse_reset();
      chk("stk_rst_ovf", 64'(ovf_sticky), 64'd0);
      chk("stk_rst_udf", 64'(udf_sticky), 64'd0);
      for (int k = 0; k < 4; k++) do_op(1, 1, 0, 32'(k));
      chk("stk_no_ovf", 64'(ovf_sticky[1]), 64'd0);
      do_op(1, 1, 0, 32'hF);
      chk("stk_ovf_set", 64'(ovf_sticky), 64'h02);
      do_op(3, 0, 1, 0);
      chk("stk_udf_set", 64'(udf_sticky), 64'h08);
      do_op(6, 0, 1, 0);
      chk("stk_ill_none", 64'(udf_sticky), 64'h08);
      err_clr = 5'b00010;
      @(posedge clock); #1;
      err_clr = '0;
      chk("stk_ovf_clr", 64'(ovf_sticky), 64'd0);
      chk("stk_udf_kept", 64'(udf_sticky), 64'h08);
`endif

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
